// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared types and constants for the instruction fetch sequencer
package mips_fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
  localparam logic [31:0] NULL_OP = 32'h0;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// inst_fetch_ctrl_if: instruction memory bus plus decode-side instruction stream
interface inst_fetch_ctrl_if;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_rvalid, imem_rdata, inst_ready
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_rvalid, imem_rdata, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer of {pc, instr} entries; flush wins over push
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rd];
  // a pop coinciding with flush is simply absorbed by the pointer clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      rd    <= rd + AW'(do_pop);
      wr    <= wr + AW'(do_push);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr] <= din;
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetch PC sequencer with single outstanding request, redirect flush and null-op halt
module inst_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  inst_fetch_ctrl_if.master    bus,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 halted,
  output logic [31:0]          halt_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state, state_nx;
  logic [31:0] fetch_pc, req_pc;
  logic outstanding, drop;
  logic resp, redir, accept, null_hit, push, pop, req;
  fetch_entry_t din, head;
  logic full, empty;
  logic [CW-1:0] count;
  assign resp     = bus.imem_rvalid & outstanding;
  assign redir    = redirect_valid & (state != HALT);
  assign accept   = resp & ~drop & ~redir & (state == RUN);
  assign null_hit = accept & (bus.imem_rdata == NULL_OP);
  assign pop      = bus.inst_valid & bus.inst_ready;
  assign push     = accept & ~null_hit & (~full | pop);
  assign din      = '{pc: req_pc, instr: bus.imem_rdata};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE && start) ? RUN : (null_hit ? HALT : state);
  always_comb begin
    req            = (state == RUN) && !outstanding && (count < CW'(FIFO_DEPTH)) && !redirect_valid;
    bus.imem_req   = req;
    bus.imem_addr  = fetch_pc[31:2];
    bus.inst_valid = ~empty;
    bus.inst_data  = empty ? '0 : head.instr;
    bus.inst_pc    = empty ? '0 : head.pc;
  end
  // a response racing a redirect is discarded; one still in flight is marked for dropping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      halted      <= 1'b0;
      halt_pc     <= '0;
    end else begin
      if (req) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
      end else if (resp) outstanding <= 1'b0;
      if (resp) drop <= 1'b0;
      else if (redir && outstanding) drop <= 1'b1;
      if (redir) fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (push) fetch_pc <= req_pc + 32'd4;
      if (null_hit) begin
        halted  <= 1'b1;
        halt_pc <= req_pc;
      end
    end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: randomized fetch traffic checked against an instruction-stream reference
module tb_inst_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic halted;
  logic [31:0] halt_pc;
  inst_fetch_ctrl_if bus ();
  inst_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .halt_pc        (halt_pc)
  );
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  int n_deliv = 0;
  int lat_min = 0;
  int lat_max = 0;
  int mem_delay = 0;
  logic mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] null_addr = 32'h0040_000C;
  logic [31:0] exp_pc = 32'h0040_0000;
  logic [29:0] req_log [$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == null_addr) return 32'h0;
    if (a == 32'h0040_0000) return 32'h3C08_0001;
    if (a == 32'h0040_0004) return 32'h3508_0002;
    return ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000) | 32'h1;
  endfunction
  function automatic logic [29:0] log_at(input int i);
    return (i < req_log.size()) ? req_log[i] : '1;
  endfunction
  // decode expects consecutive words from the last start point; a taken redirect restarts it
  task automatic step(input logic rdy, input logic rd, input logic [31:0] rd_pc, input logic st = 1'b0);
    logic resp_now, busy0;
    @(negedge clk);
    resp_now = mem_busy && mem_delay == 0;
    bus.imem_rvalid = resp_now;
    bus.imem_rdata = resp_now ? mem_word(mem_addr) : $urandom;
    bus.inst_ready = rdy;
    redirect_valid = rd;
    redirect_pc = rd_pc;
    start = st;
    #1;
    if (bus.inst_valid && rdy) begin
      chk("inst_pc", 64'(bus.inst_pc), 64'(exp_pc));
      chk("inst_data", 64'(bus.inst_data), 64'(mem_word(exp_pc)));
      exp_pc += 32'd4;
      n_deliv++;
    end
    if (rd && !halted) begin
      exp_pc = {rd_pc[31:2], 2'b00};
      chk("req_in_redirect", 64'(bus.imem_req), 64'd0);
    end
    if (halted) chk("req_in_halt", 64'(bus.imem_req), 64'd0);
    busy0 = mem_busy;
    if (resp_now) mem_busy = 1'b0;
    else if (mem_busy) mem_delay--;
    if (bus.imem_req) begin
      chk("one_outstanding", 64'(busy0), 64'd0);
      mem_busy = 1'b1;
      mem_addr = {bus.imem_addr, 2'b00};
      mem_delay = $urandom_range(lat_max, lat_min);
      req_log.push_back(bus.imem_addr);
    end
  endtask
  task automatic do_reset(input bit keep_mem);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.inst_ready = 1'b0;
    #1;
    chk("rst_req", 64'(bus.imem_req), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'h0010_0000);
    chk("rst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_data", 64'({bus.inst_pc, bus.inst_data}), 64'd0);
    chk("rst_halt", 64'({halted, halt_pc}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 32'h0040_0000;
    req_log.delete();
    if (!keep_mem) mem_busy = 1'b0;
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bit found;
    int n0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.inst_ready = 1'b0;
    do_reset(0);
    step(0, 0, 0, 1);
    repeat (8) step(0, 0, 0);
    chk("t1_nreq", 64'(req_log.size()), 64'd2);
    chk("t1_addr0", 64'(log_at(0)), 64'h0010_0000);
    chk("t1_addr1", 64'(log_at(1)), 64'h0010_0001);
    chk("t2_full_valid", 64'(bus.inst_valid), 64'd1);
    chk("t2_head_pc", 64'(bus.inst_pc), 64'h0040_0000);
    step(1, 0, 0);
    lat_min = 2;
    lat_max = 2;
    for (int i = 0; i < 10 && req_log.size() < 3; i++) step(0, 0, 0);
    chk("t2_resume", 64'(log_at(2)), 64'h0010_0002);
    step(0, 1, 32'h0040_0043);
    lat_min = 0;
    lat_max = 0;
    for (int i = 0; i < 12 && req_log.size() < 4; i++) step(0, 0, 0);
    chk("t3_redirect_addr", 64'(log_at(3)), 64'h0010_0010);
    n0 = n_deliv;
    repeat (4) step(1, 0, 0);
    chk("t3_delivered", 64'(n_deliv > n0), 64'd1);
    found = 0;
    for (int i = 0; i < 30 && !found; i++)
      if (mem_busy && mem_delay == 0 && bus.inst_valid) begin
        step(1, 1, 32'h0040_0100);
        found = 1;
      end else step(0, 0, 0);
    chk("t4_found", 64'(found), 64'd1);
    @(posedge clk);
    #1;
    chk("t4_empty", 64'(bus.inst_valid), 64'd0);
    step(0, 1, 32'h0040_0000);
    for (int i = 0; i < 80 && !halted; i++) step(1'($urandom % 2), 0, 0);
    chk("t5_halted", 64'(halted), 64'd1);
    chk("t5_halt_pc", 64'(halt_pc), 64'h0040_000C);
    step(0, 1, 32'h0040_0080);
    repeat (6) step(1, 0, 0);
    chk("t5_drained", 64'(bus.inst_valid), 64'd0);
    chk("t5_stream_end", 64'(exp_pc), 64'h0040_000C);
    chk("t5_sticky", 64'(halted), 64'd1);
    do_reset(0);
    null_addr = 32'h8000_0000;
    lat_min = 3;
    lat_max = 3;
    step(0, 0, 0, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++)
      if (mem_busy && bus.inst_valid) found = 1;
      else step(0, 0, 0);
    chk("t6_found", 64'(found), 64'd1);
    do_reset(1);
    repeat (8) begin
      step(1, 0, 0);
      chk("t6_idle", 64'({bus.inst_valid, bus.imem_req, halted}), 64'd0);
    end
    lat_min = 0;
    lat_max = 2;
    step(1, 0, 0, 1);
    n0 = n_deliv;
    repeat (3000) begin
      logic [31:0] tgt;
      tgt = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : (32'h0040_0000 + ($urandom % 1024));
      step(1'(($urandom % 4) != 0), 1'(($urandom % 20) == 0), tgt);
    end
    chk("rand_progress", 64'(n_deliv - n0 >= 300), 64'd1);
    chk("rand_not_halted", 64'(halted), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
